// File: rtl/rom_arbiter.sv
// Two-port arbiter for a shared synchronous-read ROM: IF and LD each get one
// outstanding read, and results are held until the owning port accepts them.
module rom_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              if_rsp_ready,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_req_ready,
  output logic              ld_rsp_valid,
  output logic [DATA_W-1:0] ld_rsp_data,
  output logic              ld_rsp_err,
  input  logic              ld_rsp_ready,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Index 0 = IF, index 1 = LD
  logic [1:0]        r_st      [2];
  logic [DATA_W-1:0] r_hold    [2];
  logic              r_err     [2];
  logic              r_last_ld;
  logic [ADDR_W-1:0] r_last_addr;

  logic              w_req_valid [2];
  logic [ADDR_W-1:0] w_req_addr  [2];
  logic              w_rsp_ready [2];
  logic              w_elig      [2];
  logic              w_grant     [2];
  logic              w_addr_err  [2];

  assign w_req_valid[0] = if_req_valid;
  assign w_req_valid[1] = ld_req_valid;
  assign w_req_addr[0]  = if_req_addr;
  assign w_req_addr[1]  = ld_req_addr;
  assign w_rsp_ready[0] = if_rsp_ready;
  assign w_rsp_ready[1] = ld_rsp_ready;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_elig[p]     = (r_st[p] == S_IDLE) && w_req_valid[p];
      w_addr_err[p] = (w_req_addr[p][1:0] != 2'b00) ||
                      ((w_req_addr[p] >> (IDX_W + 2)) != '0);
    end
  end

  // On a tie, LD wins unless round-robin says IF is owed the slot
  always_comb begin
    w_grant[0] = 1'b0;
    w_grant[1] = 1'b0;
    if (w_elig[0] && w_elig[1]) begin
      w_grant[1] = !RR_EN || !r_last_ld;
      w_grant[0] = !w_grant[1];
    end else begin
      w_grant[0] = w_elig[0];
      w_grant[1] = w_elig[1];
    end
  end

  always_comb begin
    rom_address = r_last_addr;
    if (w_grant[1])      rom_address = ld_req_addr;
    else if (w_grant[0]) rom_address = if_req_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < 2; p++) begin
        r_st[p]   <= S_IDLE;
        r_hold[p] <= '0;
        r_err[p]  <= 1'b0;
      end
      r_last_ld   <= 1'b0;
      r_last_addr <= '0;
    end else begin
      if (w_grant[0] || w_grant[1]) begin
        r_last_ld   <= w_grant[1];
        r_last_addr <= rom_address;
      end
      for (int unsigned p = 0; p < 2; p++) begin
        case (r_st[p])
          S_IDLE: if (w_grant[p]) begin
            r_st[p]  <= S_WAIT;
            r_err[p] <= w_addr_err[p];
          end
          // rom_data is only ours for this one cycle; latch it if the port stalls
          S_WAIT: if (w_rsp_ready[p]) r_st[p] <= S_IDLE;
                  else begin
                    r_st[p]   <= S_HOLD;
                    r_hold[p] <= rom_data;
                  end
          S_HOLD: if (w_rsp_ready[p]) r_st[p] <= S_IDLE;
          default: r_st[p] <= S_IDLE;
        endcase
      end
    end
  end

  assign if_req_ready = w_grant[0];
  assign ld_req_ready = w_grant[1];
  assign if_rsp_valid = (r_st[0] != S_IDLE);
  assign ld_rsp_valid = (r_st[1] != S_IDLE);
  assign if_rsp_data  = (r_st[0] == S_WAIT) ? rom_data : r_hold[0];
  assign ld_rsp_data  = (r_st[1] == S_WAIT) ? rom_data : r_hold[1];
  assign if_rsp_err   = r_err[0] && if_rsp_valid;
  assign ld_rsp_err   = r_err[1] && ld_rsp_valid;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter; the ROM model returns the word index as data.
module tb_rom_arbiter;
  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // round-robin instance
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err, if_rsp_ready;
  logic        ld_req_valid, ld_req_ready, ld_rsp_valid, ld_rsp_err, ld_rsp_ready;
  logic [31:0] if_req_addr, ld_req_addr, if_rsp_data, ld_rsp_data, rom_address, rom_data;
  // fixed-priority instance
  logic        b_if_req_valid, b_if_req_ready, b_if_rsp_valid, b_if_rsp_err, b_if_rsp_ready;
  logic        b_ld_req_valid, b_ld_req_ready, b_ld_rsp_valid, b_ld_rsp_err, b_ld_rsp_ready;
  logic [31:0] b_if_req_addr, b_ld_req_addr, b_if_rsp_data, b_ld_rsp_data, b_rom_address, b_rom_data;

  rom_arbiter #(.ADDR_W(32), .DATA_W(32), .IDX_W(8), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .if_rsp_ready(if_rsp_ready),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
    .ld_rsp_ready(ld_rsp_ready),
    .rom_address(rom_address), .rom_data(rom_data));

  rom_arbiter #(.ADDR_W(32), .DATA_W(32), .IDX_W(8), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(b_if_req_valid), .if_req_addr(b_if_req_addr), .if_req_ready(b_if_req_ready),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data), .if_rsp_err(b_if_rsp_err),
    .if_rsp_ready(b_if_rsp_ready),
    .ld_req_valid(b_ld_req_valid), .ld_req_addr(b_ld_req_addr), .ld_req_ready(b_ld_req_ready),
    .ld_rsp_valid(b_ld_rsp_valid), .ld_rsp_data(b_ld_rsp_data), .ld_rsp_err(b_ld_rsp_err),
    .ld_rsp_ready(b_ld_rsp_ready),
    .rom_address(b_rom_address), .rom_data(b_rom_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM: word[i] = i, one-cycle registered output
  always @(posedge clk) begin
    rom_data   <= {24'h0, rom_address[9:2]};
    b_rom_data <= {24'h0, b_rom_address[9:2]};
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req_valid = 0; if_req_addr = 0; if_rsp_ready = 0;
    ld_req_valid = 0; ld_req_addr = 0; ld_rsp_ready = 0;
    b_if_req_valid = 0; b_if_req_addr = 0; b_if_rsp_ready = 0;
    b_ld_req_valid = 0; b_ld_req_addr = 0; b_ld_rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mid();
    n_cmp++; if (if_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_if_valid got=%b exp=0", if_rsp_valid); end
    n_cmp++; if (ld_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_ld_valid got=%b exp=0", ld_rsp_valid); end
    n_cmp++; if ({if_rsp_err, ld_rsp_err} !== 2'b00) begin n_err++; $display("FAIL rst_err got=%b exp=00", {if_rsp_err, ld_rsp_err}); end
    n_cmp++; if (rom_address !== 32'h0) begin n_err++; $display("FAIL rst_rom_addr got=%h exp=0", rom_address); end
    n_cmp++; if ({if_req_ready, ld_req_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready got=%b exp=00", {if_req_ready, ld_req_ready}); end
    next();
  endtask

  task automatic test_single_if();
    if_req_valid = 1; if_req_addr = 32'h14; if_rsp_ready = 1; ld_rsp_ready = 1;
    mid();
    n_cmp++; if ({if_req_ready, ld_req_ready} !== 2'b10) begin n_err++; $display("FAIL t1_ready got=%b exp=10", {if_req_ready, ld_req_ready}); end
    n_cmp++; if (rom_address !== 32'h14) begin n_err++; $display("FAIL t1_rom_addr got=%h exp=14", rom_address); end
    next();
    if_req_valid = 0;
    mid();
    n_cmp++; if (if_rsp_valid !== 1'b1) begin n_err++; $display("FAIL t1_rsp_valid got=%b exp=1", if_rsp_valid); end
    n_cmp++; if (if_rsp_data !== 32'h5) begin n_err++; $display("FAIL t1_rsp_data got=%h exp=5", if_rsp_data); end
    n_cmp++; if (if_rsp_err !== 1'b0) begin n_err++; $display("FAIL t1_rsp_err got=%b exp=0", if_rsp_err); end
    n_cmp++; if (rom_address !== 32'h14) begin n_err++; $display("FAIL t1_addr_hold got=%h exp=14", rom_address); end
    next();
    mid();
    n_cmp++; if (if_rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_idle got=%b exp=0", if_rsp_valid); end
    next();
  endtask

  task automatic test_back_to_back();
    logic        exp_ld;
    logic [31:0] exp_a;
    if_req_valid = 1; if_req_addr = 32'h08; ld_req_valid = 1; ld_req_addr = 32'h0C;
    if_rsp_ready = 1; ld_rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      mid();
      exp_ld = (k % 2 == 0);
      exp_a  = exp_ld ? 32'h0C : 32'h08;
      n_cmp++; if ({if_req_ready, ld_req_ready} !== {!exp_ld, exp_ld}) begin n_err++; $display("FAIL t2_grant k=%0d got=%b exp=%b", k, {if_req_ready, ld_req_ready}, {!exp_ld, exp_ld}); end
      n_cmp++; if (rom_address !== exp_a) begin n_err++; $display("FAIL t2_rom_addr k=%0d got=%h exp=%h", k, rom_address, exp_a); end
      if (k > 0 && !exp_ld) begin
        n_cmp++; if ({ld_rsp_valid, if_rsp_valid, ld_rsp_data} !== {2'b10, 32'h3}) begin n_err++; $display("FAIL t2_ld_rsp k=%0d got=%b%b %h exp=10 3", k, ld_rsp_valid, if_rsp_valid, ld_rsp_data); end
      end
      if (k > 0 && exp_ld) begin
        n_cmp++; if ({if_rsp_valid, ld_rsp_valid, if_rsp_data} !== {2'b10, 32'h2}) begin n_err++; $display("FAIL t2_if_rsp k=%0d got=%b%b %h exp=10 2", k, if_rsp_valid, ld_rsp_valid, if_rsp_data); end
      end
      next();
    end
    if_req_valid = 0; ld_req_valid = 0;
    mid();
    n_cmp++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h2}) begin n_err++; $display("FAIL t2_drain got=%b %h exp=1 2", if_rsp_valid, if_rsp_data); end
    next();
  endtask

  task automatic test_ld_stall();
    ld_req_valid = 1; ld_req_addr = 32'h40; ld_rsp_ready = 0;
    mid();
    n_cmp++; if (ld_req_ready !== 1'b1) begin n_err++; $display("FAIL t3_ld_accept got=%b exp=1", ld_req_ready); end
    next();
    ld_req_valid = 0; if_req_valid = 1; if_req_addr = 32'h04; if_rsp_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      mid();
      n_cmp++; if ({ld_rsp_valid, ld_rsp_data} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL t3_ld_hold k=%0d got=%b %h exp=1 10", k, ld_rsp_valid, ld_rsp_data); end
      if (k == 1) begin
        n_cmp++; if (if_req_ready !== 1'b1) begin n_err++; $display("FAIL t3_if_accept got=%b exp=1", if_req_ready); end
      end
      if (k == 2) begin
        n_cmp++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h1}) begin n_err++; $display("FAIL t3_if_rsp got=%b %h exp=1 1", if_rsp_valid, if_rsp_data); end
      end
      next();
      if_req_valid = 0;
    end
    ld_rsp_ready = 1; ld_req_valid = 1; ld_req_addr = 32'h14;
    mid();
    n_cmp++; if ({ld_rsp_valid, ld_rsp_data} !== {1'b1, 32'h10}) begin n_err++; $display("FAIL t3_ld_release got=%b %h exp=1 10", ld_rsp_valid, ld_rsp_data); end
    n_cmp++; if (ld_req_ready !== 1'b0) begin n_err++; $display("FAIL t3_no_same_cycle_accept got=%b exp=0", ld_req_ready); end
    next();
    mid();
    n_cmp++; if ({ld_req_ready, ld_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL t3_reaccept got=%b exp=10", {ld_req_ready, ld_rsp_valid}); end
    next();
    ld_req_valid = 0;
    mid();
    n_cmp++; if ({ld_rsp_valid, ld_rsp_data} !== {1'b1, 32'h5}) begin n_err++; $display("FAIL t3_second_rsp got=%b %h exp=1 5", ld_rsp_valid, ld_rsp_data); end
    next();
  endtask

  task automatic test_fixed_priority();
    logic [5:0] exp_ld = 6'b010101;
    logic [5:0] exp_if = 6'b100010;
    b_if_req_valid = 1; b_if_req_addr = 32'h08; b_ld_req_valid = 1; b_ld_req_addr = 32'h0C;
    b_ld_rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      b_if_rsp_ready = (k != 2);
      mid();
      n_cmp++; if ({b_if_req_ready, b_ld_req_ready} !== {exp_if[k], exp_ld[k]}) begin n_err++; $display("FAIL t4_grant k=%0d got=%b exp=%b", k, {b_if_req_ready, b_ld_req_ready}, {exp_if[k], exp_ld[k]}); end
      next();
    end
    b_if_req_valid = 0; b_ld_req_valid = 0;
    mid();
    n_cmp++; if ({b_if_rsp_valid, b_if_rsp_data} !== {1'b1, 32'h2}) begin n_err++; $display("FAIL t4_if_rsp got=%b %h exp=1 2", b_if_rsp_valid, b_if_rsp_data); end
    next();
  endtask

  task automatic test_addr_err();
    if_req_valid = 1; if_req_addr = 32'h06; ld_req_valid = 1; ld_req_addr = 32'h400;
    if_rsp_ready = 0; ld_rsp_ready = 0;
    mid();
    n_cmp++; if ({if_req_ready, ld_req_ready} !== 2'b10) begin n_err++; $display("FAIL t5_rr_tie got=%b exp=10", {if_req_ready, ld_req_ready}); end
    next();
    if_req_valid = 0;
    mid();
    n_cmp++; if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== {2'b11, 32'h1}) begin n_err++; $display("FAIL t5_if_misalign got=%b%b %h exp=11 1", if_rsp_valid, if_rsp_err, if_rsp_data); end
    n_cmp++; if (ld_req_ready !== 1'b1) begin n_err++; $display("FAIL t5_ld_accept got=%b exp=1", ld_req_ready); end
    next();
    ld_req_valid = 0;
    mid();
    n_cmp++; if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== {2'b11, 32'h1}) begin n_err++; $display("FAIL t5_if_hold got=%b%b %h exp=11 1", if_rsp_valid, if_rsp_err, if_rsp_data); end
    n_cmp++; if ({ld_rsp_valid, ld_rsp_err, ld_rsp_data} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL t5_ld_range got=%b%b %h exp=11 0", ld_rsp_valid, ld_rsp_err, ld_rsp_data); end
    next();
    if_rsp_ready = 1; ld_rsp_ready = 1;
    mid();
    n_cmp++; if ({if_rsp_valid, if_rsp_data, ld_rsp_valid, ld_rsp_data} !== {1'b1, 32'h1, 1'b1, 32'h0}) begin n_err++; $display("FAIL t5_both_complete got=%b %h %b %h exp=1 1 1 0", if_rsp_valid, if_rsp_data, ld_rsp_valid, ld_rsp_data); end
    next();
    mid();
    n_cmp++; if ({if_rsp_valid, ld_rsp_valid, if_rsp_err, ld_rsp_err} !== 4'b0000) begin n_err++; $display("FAIL t5_both_idle got=%b exp=0000", {if_rsp_valid, ld_rsp_valid, if_rsp_err, ld_rsp_err}); end
    next();
  endtask

  task automatic test_reset_in_flight();
    if_req_valid = 1; if_req_addr = 32'h14; if_rsp_ready = 1;
    mid();
    n_cmp++; if (if_req_ready !== 1'b1) begin n_err++; $display("FAIL t6_accept got=%b exp=1", if_req_ready); end
    next();
    if_req_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b0) begin n_err++; $display("FAIL t6_async_drop got=%b exp=0", if_rsp_valid); end
    n_cmp++; if (rom_address !== 32'h0) begin n_err++; $display("FAIL t6_rst_addr got=%h exp=0", rom_address); end
    next();
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mid();
      n_cmp++; if (if_rsp_valid !== 1'b0) begin n_err++; $display("FAIL t6_no_rsp k=%0d got=%b exp=0", k, if_rsp_valid); end
      next();
    end
    if_req_valid = 1; if_req_addr = 32'h08;
    mid();
    n_cmp++; if (if_req_ready !== 1'b1) begin n_err++; $display("FAIL t6_new_accept got=%b exp=1", if_req_ready); end
    next();
    if_req_valid = 0;
    mid();
    n_cmp++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h2}) begin n_err++; $display("FAIL t6_new_rsp got=%b %h exp=1 2", if_rsp_valid, if_rsp_data); end
    next();
  endtask

  initial begin
    test_reset();
    test_single_if();
    test_back_to_back();
    test_ld_stall();
    test_fixed_priority();
    test_addr_err();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
